// File: rtl/seq_array_mult.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_array_mult : sequential shift-and-add unsigned multiplier, one       |
// |                  partial-product row per clock, start/done handshake.    |
// | Option macro   : MULT_ACCUM_EN (multiply-accumulate into s)              |
// | Revision       : 1.0  initial release                                    |
// +--------------------------------------------------------------------------+
module seq_array_mult #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           acc_clr,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] s
);

  localparam int            CW     = $clog2(N + 1);
  localparam int            PW     = 2 * N;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [N-1:0]    mcand_q;
  logic [N-1:0]    mplier_q;
  logic [PW-1:0]   part_q;
  logic [PW-1:0]   part_d;
  logic [PW-1:0]   row;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [PW-1:0]   s_q;
  logic [PW-1:0]   s_d;
  logic            last;

  assign last   = (state_q == S_RUN) && (cnt_q == C_LAST);
  assign row    = mplier_q[0] ? ({{N{1'b0}}, mcand_q} << cnt_q) : '0;
  assign part_d = part_q + row;

`ifdef MULT_ACCUM_EN
  // Clear and completion on the same edge: clear first, then add this product.
  always_comb begin
    s_d = s_q;
    if (last) begin
      s_d = acc_clr ? part_d : (s_q + part_d);
    end else if (acc_clr) begin
      s_d = '0;
    end
  end
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr;

  always_comb begin
    s_d = s_q;
    if (last) begin
      s_d = part_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      part_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      s_q      <= '0;
    end else begin
      done_q <= 1'b0;
      s_q    <= s_d;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            mcand_q  <= a;
            mplier_q <= b;
            part_q   <= '0;
            cnt_q    <= '0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          // Fixed N iterations; no early exit when the multiplier runs out of ones.
          part_q   <= part_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + C_ONE;
          if (last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_array_mult.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seq_array_mult : directed self-checking bench for seq_array_mult      |
// |                     (N=2, N=4, N=8 instances; MULT_ACCUM_EN aware).      |
// | Revision          : 1.0  initial release                                 |
// +--------------------------------------------------------------------------+
module tb_seq_array_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        st2 = 1'b0, clr2 = 1'b0, busy2, done2;
  logic [1:0]  a2 = '0, b2 = '0;
  logic [3:0]  s2;

  logic        st4 = 1'b0, clr4 = 1'b0, busy4, done4;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  s4;

  logic        st8 = 1'b0, clr8 = 1'b0, busy8, done8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] s8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_array_mult #(.N(2)) u2 (
    .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .acc_clr(clr2),
    .busy(busy2), .done(done2), .s(s2)
  );
  seq_array_mult #(.N(4)) u4 (
    .clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4), .acc_clr(clr4),
    .busy(busy4), .done(done4), .s(s4)
  );
  seq_array_mult #(.N(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .acc_clr(clr8),
    .busy(busy8), .done(done8), .s(s8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start an N=4 multiply and return in its done cycle (cycle 5).
  task automatic mul4(input logic [3:0] x, input logic [3:0] y, input logic clr_last);
    a4  = x;
    b4  = y;
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    repeat (3) tick();
    clr4 = clr_last;
    tick();
    clr4 = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_s4",    s4,    0);
    chk("rst_s8",    s8,    0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_busy4", busy4, 0);

    // N=2 exhaustive, back-to-back from the DONE cycle
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        a2  = 2'(i);
        b2  = 2'(j);
        st2 = 1'b1;
        tick();
        st2 = 1'b0;
        chk("n2_busy_c1", busy2, 1);
        tick();
        chk("n2_done_c2", done2, 0);
        tick();
        chk("n2_done_c3", done2, 1);
        chk("n2_s", s2, i * j);
      end
    end
    tick();
    chk("n2_idle_done", done2, 0);

    // N=8 all-ones and zero multiplicand, fixed 9-cycle latency
    a8 = 8'hFF; b8 = 8'hFF; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("n8_busy", busy8, 1);
      chk("n8_nodone", done8, 0);
      tick();
    end
    chk("n8_done_ff", done8, 1);
    chk("n8_busy_off", busy8, 0);
    chk("n8_s_ff", s8, 16'hFE01);
    tick();
    chk("n8_pulse_end", done8, 0);
    a8 = 8'h00; b8 = 8'hA5; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    repeat (7) tick();
    chk("n8_hold_c8", s8, 16'hFE01);
    chk("n8_zero_c8_done", done8, 0);
    tick();
    chk("n8_done_zero", done8, 1);
    chk("n8_s_zero", s8, 16'h0000);

    // start during busy is ignored; operands not re-sampled
    a4 = 4'd5; b4 = 4'd6; st4 = 1'b1;
    tick();
    st4 = 1'b0; a4 = 4'd7; b4 = 4'd7;
    tick();
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    chk("ign_busy_c3", busy4, 1);
    tick();
    chk("ign_nodone_c4", done4, 0);
    tick();
    chk("ign_done_c5", done4, 1);
    chk("ign_s", s4, 8'd30);
    tick();
    chk("ign_idle_done", done4, 0);
    chk("ign_idle_busy", busy4, 0);
    repeat (5) tick();
    chk("ign_no_second", done4, 0);
    chk("ign_s_hold", s4, 8'd30);

    // asynchronous reset mid-operation
    a4 = 4'd9; b4 = 4'd9; st4 = 1'b1;
    tick();
    st4 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("arst_busy", busy4, 0);
    chk("arst_done", done4, 0);
    chk("arst_s", s4, 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("arst_no_done", done4, 0);
    end
    mul4(4'd2, 4'd3, 1'b0);
    chk("post_rst_done", done4, 1);
    chk("post_rst_s", s4, 8'd6);
    tick();

    // start held through DONE: back-to-back with new operands
    a4 = 4'd3; b4 = 4'd4; st4 = 1'b1;
    tick();
    a4 = 4'd2; b4 = 4'd5;
    repeat (3) tick();
    tick();
    chk("b2b_done_c5", done4, 1);
    chk("b2b_s_12", s4, 8'd12);
    tick();
    chk("b2b_busy_c6", busy4, 1);
    chk("b2b_nodone_c6", done4, 0);
    chk("b2b_hold_c6", s4, 8'd12);
    repeat (3) tick();
    tick();
    st4 = 1'b0;
    chk("b2b_done_c10", done4, 1);
    chk("b2b_s_10", s4, 8'd10);
    tick();

`ifdef MULT_ACCUM_EN
    // accumulate mode
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    chk("acc_clear", s4, 0);
    mul4(4'd3, 4'd4, 1'b0);
    chk("acc_12", s4, 8'd12);
    mul4(4'd5, 4'd5, 1'b0);
    chk("acc_37", s4, 8'd37);
    for (int k = 0; k < 4; k++) mul4(4'd15, 4'd15, 1'b0);
    chk("acc_wrap_169", s4, 8'd169);
    mul4(4'd2, 4'd2, 1'b1);
    chk("acc_clr_coincident", s4, 8'd4);
`else
    // acc_clr has no effect without the accumulator
    mul4(4'd3, 4'd4, 1'b1);
    chk("noacc_s_12", s4, 8'd12);
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    chk("noacc_clr_ignored", s4, 8'd12);
    mul4(4'd15, 4'd15, 1'b0);
    chk("noacc_s_225", s4, 8'd225);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
